ram_bist_ctrl: RTL and testbench

RAM_BIST_CTRL -- requirements
Module: ram_bist_ctrl

---
 rtl/ram_bist_pkg.sv | 20 ++
 rtl/ram_bist_ctrl_if.sv | 31 +++
 rtl/ram_bist_cmp.sv | 57 +++++
 rtl/ram_bist_ctrl.sv | 168 ++++++++++++++++
 tb/tb_ram_bist_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_bist_pkg.sv
// Shared definitions for the RAM BIST controller: FSM state encoding and default geometry.
// States WRITE_INV/READ_INV exist only when RAM_BIST_INVERT_EN is defined.
package ram_bist_pkg;

    localparam int BIST_ADDR_W = 10;
    localparam int BIST_DATA_W = 8;
    localparam int BIST_DEPTH  = 1024;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WRITE     = 3'd1,
        S_READ      = 3'd2,
`ifdef RAM_BIST_INVERT_EN
        S_WRITE_INV = 3'd3,
        S_READ_INV  = 3'd4,
`endif
        S_DONE      = 3'd5
    } bist_state_e;

endpackage

// File: rtl/ram_bist_ctrl_if.sv
// RAM-side bus of the BIST controller; master = controller, slave = memory.
interface ram_bist_ctrl_if
    import ram_bist_pkg::*;
#(
    parameter int ADDR_W = BIST_ADDR_W,
    parameter int DATA_W = BIST_DATA_W
);

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data_in;
    logic              mem_wr;
    logic              mem_cs;
    logic [DATA_W-1:0] mem_data_out;

    modport master (
        output mem_addr,
        output mem_data_in,
        output mem_wr,
        output mem_cs,
        input  mem_data_out
    );

    modport slave (
        input  mem_addr,
        input  mem_data_in,
        input  mem_wr,
        input  mem_cs,
        output mem_data_out
    );

endinterface

// File: rtl/ram_bist_cmp.sv
// Read-back comparator: first-mismatch capture and mismatch counter for one BIST run.
// With RAM_BIST_INVERT_EN undefined the counter's top bit is tied to 0 (at most DEPTH errors).
module ram_bist_cmp
    import ram_bist_pkg::*;
#(
    parameter int ADDR_W = BIST_ADDR_W,
    parameter int DATA_W = BIST_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] rd_data,
    input  logic [DATA_W-1:0] exp_data,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data,
    output logic [ADDR_W+1:0] err_count
);

`ifdef RAM_BIST_INVERT_EN
    localparam int CNT_W = ADDR_W + 2;
`else
    localparam int CNT_W = ADDR_W + 1;
`endif

    logic [CNT_W-1:0] cnt;
    logic             mismatch;

    assign mismatch = en && (rd_data != exp_data);

`ifdef RAM_BIST_INVERT_EN
    assign err_count = cnt;
`else
    assign err_count = {1'b0, cnt};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            fail_addr <= '0;
            fail_data <= '0;
        end else if (clr) begin
            cnt       <= '0;
            fail_addr <= '0;
            fail_data <= '0;
        end else if (mismatch) begin
            // Only the first mismatch of the run is captured; the rest just count.
            if (cnt == '0) begin
                fail_addr <= addr;
                fail_data <= rd_data;
            end
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/ram_bist_ctrl.sv
// RAM BIST controller: writes exp(a) = 2a mod 2**DATA_W to every word, reads it back and checks.
// Define RAM_BIST_INVERT_EN to append an inverted write/read pass (pattern ~exp(a)).
module ram_bist_ctrl
    import ram_bist_pkg::*;
#(
    parameter int ADDR_W = BIST_ADDR_W,
    parameter int DATA_W = BIST_DATA_W,
    parameter int DEPTH  = BIST_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    ram_bist_ctrl_if.master   mem,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data,
    output logic [ADDR_W+1:0] err_count
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a);
        return DATA_W'({a, 1'b0});
    endfunction

    bist_state_e       state;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              wr_q;
    logic              cs_q;

    logic [ADDR_W-1:0] addr_nxt;
    logic              start_ok;
    logic              rd_phase;
    logic              inv_phase;
    logic [DATA_W-1:0] exp_data;

    assign addr_nxt = addr_q + ADDR_W'(1);
    assign start_ok = (state == S_IDLE) && start && !abort;

`ifdef RAM_BIST_INVERT_EN
    assign rd_phase  = (state == S_READ) || (state == S_READ_INV);
    assign inv_phase = (state == S_READ_INV);
`else
    assign rd_phase  = (state == S_READ);
    assign inv_phase = 1'b0;
`endif

    assign exp_data = pattern(addr_q) ^ {DATA_W{inv_phase}};

    assign mem.mem_addr    = addr_q;
    assign mem.mem_data_in = wdata_q;
    assign mem.mem_wr      = wr_q;
    assign mem.mem_cs      = cs_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            cs_q    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            pass    <= 1'b0;
        end else if (abort && busy) begin
            state   <= S_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            cs_q    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_ok) begin
                        state   <= S_WRITE;
                        addr_q  <= '0;
                        wdata_q <= pattern('0);
                        wr_q    <= 1'b1;
                        cs_q    <= 1'b1;
                        busy    <= 1'b1;
                        done    <= 1'b0;
                        pass    <= 1'b0;
                    end
                end
                S_WRITE: begin
                    if (addr_q == LAST_ADDR) begin
                        state   <= S_READ;
                        addr_q  <= '0;
                        wdata_q <= '0;
                        wr_q    <= 1'b0;
                    end else begin
                        addr_q  <= addr_nxt;
                        wdata_q <= pattern(addr_nxt);
                    end
                end
                S_READ: begin
                    if (addr_q == LAST_ADDR) begin
                        addr_q  <= '0;
`ifdef RAM_BIST_INVERT_EN
                        state   <= S_WRITE_INV;
                        wdata_q <= ~pattern('0);
                        wr_q    <= 1'b1;
`else
                        state   <= S_DONE;
                        cs_q    <= 1'b0;
                        busy    <= 1'b0;
`endif
                    end else begin
                        addr_q <= addr_nxt;
                    end
                end
`ifdef RAM_BIST_INVERT_EN
                S_WRITE_INV: begin
                    if (addr_q == LAST_ADDR) begin
                        state   <= S_READ_INV;
                        addr_q  <= '0;
                        wdata_q <= '0;
                        wr_q    <= 1'b0;
                    end else begin
                        addr_q  <= addr_nxt;
                        wdata_q <= ~pattern(addr_nxt);
                    end
                end
                S_READ_INV: begin
                    if (addr_q == LAST_ADDR) begin
                        state  <= S_DONE;
                        addr_q <= '0;
                        cs_q   <= 1'b0;
                        busy   <= 1'b0;
                    end else begin
                        addr_q <= addr_nxt;
                    end
                end
`endif
                S_DONE: begin
                    // err_count already includes the final compare made on the edge into DONE.
                    state <= S_IDLE;
                    done  <= 1'b1;
                    pass  <= (err_count == '0);
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    ram_bist_cmp #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_cmp (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (start_ok),
        .en        (rd_phase && !abort),
        .addr      (addr_q),
        .rd_data   (mem.mem_data_out),
        .exp_data  (exp_data),
        .fail_addr (fail_addr),
        .fail_data (fail_data),
        .err_count (err_count)
    );

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Scoreboard bench for ram_bist_ctrl: RAM model with injectable read faults, reference model
// of the expected run outcome, and a done-triggered monitor.
module tb_ram_bist_ctrl;
    import ram_bist_pkg::*;

    localparam int AW = BIST_ADDR_W;
    localparam int DW = BIST_DATA_W;
    localparam int D  = BIST_DEPTH;
`ifdef RAM_BIST_INVERT_EN
    localparam int NPH = 2;
`else
    localparam int NPH = 1;
`endif
    localparam int RUN_CYC = 2 * NPH * D + 1;

    typedef struct {
        logic pass;
        int   fa;
        int   fd;
        int   err;
        int   done_cyc;
    } exp_t;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          busy, done, pass;
    logic [AW-1:0] fail_addr;
    logic [DW-1:0] fail_data;
    logic [AW+1:0] err_count;

    ram_bist_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

    ram_bist_ctrl #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(D)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .mem       (bus),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .fail_addr (fail_addr),
        .fail_data (fail_data),
        .err_count (err_count)
    );

    exp_t          sb[$];
    exp_t          mon_e;
    int            n_pass = 0;
    int            n_total = 0;
    int            cyc = 0;
    int            s_idx = 0;
    int            wr_no_cs = 0;
    int            fault_mode = 0;
    int            n_cor = 0;
    logic [AW-1:0] cor_addr [4];
    logic [DW-1:0] cor_mask [4];
    logic [DW-1:0] ram [D];
    logic [DW-1:0] rd_v;
    logic          done_q;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.mem_cs && bus.mem_wr) ram[bus.mem_addr] <= bus.mem_data_in;
    end

    always @(negedge clk) begin
        if (bus.mem_wr && !bus.mem_cs) wr_no_cs <= wr_no_cs + 1;
    end

    // Fault-injecting read path: 1 = data bit 0 stuck at 1, 2 = listed words read back XORed.
    always_comb begin
        rd_v = ram[bus.mem_addr];
        if (fault_mode == 1) rd_v[0] = 1'b1;
        else if (fault_mode == 2)
            for (int i = 0; i < n_cor; i++)
                if (bus.mem_addr == cor_addr[i]) rd_v = rd_v ^ cor_mask[i];
        bus.mem_data_out = rd_v;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endtask

    function automatic int word_of(input int a, input int ph);
        int w;
        w = (2 * a) % (1 << DW);
        if (ph == 1) w = (1 << DW) - 1 - w;
        return w;
    endfunction

    function automatic exp_t model(input int sidx);
        exp_t e;
        int   found, want, got;
        found = 0;
        e.err = 0; e.fa = 0; e.fd = 0;
        for (int ph = 0; ph < NPH; ph++)
            for (int a = 0; a < D; a++) begin
                want = word_of(a, ph);
                got  = want;
                if (fault_mode == 1) got = got | 1;
                if (fault_mode == 2)
                    for (int i = 0; i < n_cor; i++)
                        if (int'(cor_addr[i]) == a) got = got ^ int'(cor_mask[i]);
                if (got != want) begin
                    if (found == 0) begin e.fa = a; e.fd = got; found = 1; end
                    e.err++;
                end
            end
        e.pass     = (e.err == 0);
        e.done_cyc = sidx + RUN_CYC;
        return e;
    endfunction

    initial begin
        done_q = 1'b0;
        forever begin
            @(negedge clk);
            if (done && !done_q) begin
                if (sb.size() == 0) check("unexpected_done", 1, 0);
                else begin
                    mon_e = sb.pop_front();
                    check("done_latency", cyc, mon_e.done_cyc);
                    check("pass", pass, mon_e.pass);
                    check("err_count", err_count, mon_e.err);
                    check("fail_addr", fail_addr, mon_e.fa);
                    check("fail_data", fail_data, mon_e.fd);
                    check("busy_at_done", busy, 0);
                    check("cs_at_done", bus.mem_cs, 0);
                    check("ram5", ram[5], word_of(5, NPH - 1));
                    check("ram200", ram[200], word_of(200, NPH - 1));
                end
            end
            done_q = done;
        end
    end

    task automatic start_run(input bit expect_done);
        @(negedge clk);
        start = 1'b1;
        s_idx = cyc + 1;
        if (expect_done) sb.push_back(model(s_idx));
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (sb.size() != 0 && n < RUN_CYC + 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (sb.size() != 0) begin
            check("run_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_pass"}, pass, 0);
        check({tag, "_wr"}, bus.mem_wr, 0);
        check({tag, "_cs"}, bus.mem_cs, 0);
        check({tag, "_addr"}, bus.mem_addr, 0);
        check({tag, "_wdata"}, bus.mem_data_in, 0);
        check({tag, "_faddr"}, fail_addr, 0);
        check({tag, "_fdata"}, fail_data, 0);
        check({tag, "_err"}, err_count, 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        repeat (3) @(negedge clk);
        check_all_zero("reset");

        // First start on the very first edge after reset release; repeated starts ignored.
        rst_n = 1'b1;
        start = 1'b1;
        s_idx = cyc + 1;
        sb.push_back(model(s_idx));
        @(negedge clk);
        start = 1'b0;
        check("first_busy", busy, 1);
        check("first_wr", bus.mem_wr, 1);
        check("first_cs", bus.mem_cs, 1);
        check("first_addr", bus.mem_addr, 0);
        for (int k = 0; k < 4; k++) begin
            repeat ($urandom_range(50, 400)) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        wait_idle();
        repeat (5) @(negedge clk);
        check("done_held", done, 1);

        // abort beats start while idle
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("abort_prio_busy", busy, 0);

        fault_mode = 1;
        start_run(1);
        check("clear_done", done, 0);
        wait_idle();

        fault_mode = 2; n_cor = 1;
        cor_addr[0] = AW'(700);
        cor_mask[0] = DW'($urandom_range(1, (1 << DW) - 1));
        start_run(1);
        check("clr_err", err_count, 0);
        check("clr_faddr", fail_addr, 0);
        check("clr_fdata", fail_data, 0);
        check("clr_pass", pass, 0);
        wait_idle();

        for (int r = 0; r < 3; r++) begin
            n_cor = $urandom_range(1, 4);
            for (int i = 0; i < n_cor; i++) begin
                cor_addr[i] = AW'($urandom_range(0, D - 1));
                cor_mask[i] = DW'($urandom_range(1, (1 << DW) - 1));
            end
            start_run(1);
            wait_idle();
        end

        fault_mode = 0;
        start_run(0);
        while (cyc < s_idx + 299) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_wr", bus.mem_wr, 0);
        check("abort_cs", bus.mem_cs, 0);
        check("abort_done", done, 0);

        start_run(0);
        t = s_idx + D + $urandom_range(1, D - 2);
        while (cyc < t) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_rd_busy", busy, 0);
        check("abort_rd_cs", bus.mem_cs, 0);

        start_run(1);
        wait_idle();

        // Asynchronous reset in the middle of the write sweep.
        start_run(0);
        while (cyc < s_idx + 100) @(negedge clk);
        check("pre_rst_wr", bus.mem_wr, 1);
        #2 rst_n = 1'b0;
        #1 check_all_zero("rst_write");
        @(negedge clk);
        rst_n = 1'b1;

        // Asynchronous reset during the read sweep with an error already logged.
        fault_mode = 2; n_cor = 1;
        cor_addr[0] = AW'($urandom_range(1, 400));
        cor_mask[0] = DW'($urandom_range(1, (1 << DW) - 1));
        start_run(0);
        while (cyc < s_idx + 1500) @(negedge clk);
        check("pre_rst_err", err_count, 1);
        check("pre_rst_faddr", fail_addr, cor_addr[0]);
        #2 rst_n = 1'b0;
        #1 check_all_zero("rst_read");
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b1;
        s_idx = cyc + 1;
        sb.push_back(model(s_idx));
        @(negedge clk);
        start = 1'b0;
        check("post_rst_busy", busy, 1);
        wait_idle();

        repeat (3) @(negedge clk);
        check("wr_without_cs", wr_no_cs, 0);
        check("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
